// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcode constants, default widths and fetch FSM encoding for the 8-bit RISC core.
package cpu_pkg;

    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DATA_W = 8;

    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDA = 3'd5;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_ISSUE = 2'd1,
        S_HALT  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/pc_next.sv
// pc_next: next program counter for the retiring instruction, modulo 2^ADDR_W.
module pc_next
    import cpu_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] operand,
    input  logic [2:0]        opcode,
    input  logic              acc_zero,
    output logic [ADDR_W-1:0] pc_nxt
);

    always_comb
        pc_nxt = (opcode == OP_JMP) ? operand
               : pc + ((opcode == OP_SKZ && acc_zero) ? ADDR_W'(2) : ADDR_W'(1));

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: owns the PC, fetches instruction bytes over a valid handshake and holds
// the decoded opcode/operand until the controller retires it; applies skip, jump and halt.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_valid,
    output logic [2:0]        opcode,
    output logic [ADDR_W-1:0] operand,
    output logic              instr_valid,
    input  logic              instr_done,
    input  logic              acc_zero,
    input  logic              resume,
    output logic              halted,
    output logic [ADDR_W-1:0] pc
);

    fetch_state_e      state_q, state_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [ADDR_W-1:0] pc_q, pc_d, pc_nxt;
    logic              mem_rd_q, mem_rd_d;
    logic              fetch_hit;

    pc_next #(.ADDR_W(ADDR_W)) u_pc_next (
        .pc       (pc_q),
        .operand  (ir_q[ADDR_W-1:0]),
        .opcode   (ir_q[DATA_W-1 -: 3]),
        .acc_zero (acc_zero),
        .pc_nxt   (pc_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_FETCH;
            ir_q     <= '0;
            pc_q     <= '0;
            mem_rd_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ir_q     <= ir_d;
            pc_q     <= pc_d;
            mem_rd_q <= mem_rd_d;
        end
    end

    // data only counts once our registered request is actually on the bus
    always_comb fetch_hit = state_q == S_FETCH && mem_rd_q && mem_valid;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: state_d = fetch_hit ? S_ISSUE : S_FETCH;
            S_ISSUE: state_d = (ir_q[DATA_W-1 -: 3] == OP_HLT) ? S_HALT
                             : instr_done ? S_FETCH : S_ISSUE;
            S_HALT:  state_d = resume ? S_FETCH : S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    always_comb begin
        ir_d     = fetch_hit ? mem_rdata : ir_q;
        pc_d     = (state_q == S_ISSUE && state_d != S_ISSUE) ? pc_nxt : pc_q;
        mem_rd_d = state_d == S_FETCH;
    end

    always_comb begin
        mem_rd      = mem_rd_q;
        mem_addr    = pc_q;
        opcode      = ir_q[DATA_W-1 -: 3];
        operand     = ir_q[ADDR_W-1:0];
        instr_valid = state_q == S_ISSUE;
        halted      = state_q == S_HALT;
        pc          = pc_q;
    end

endmodule
